// File: rtl/bus_mux_pkg.sv
// Shared constants and defaults for the bus_mux_pipe source selector.
package bus_mux_pkg;

  // Opcode field at the top of an immediate-formatted source word
  localparam int unsigned OPC_W = 3;
  localparam logic [OPC_W-1:0] MV  = 3'b000;
  localparam logic [OPC_W-1:0] MVT = 3'b001;

  // Default geometry
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_NUM_SRC = 11;
  localparam int unsigned DEF_IMM_SRC = 8;
  localparam int unsigned DEF_IMM_W   = 9;

  // Select width for n sources, never narrower than one bit
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_mux_pipe_imm_fmt.sv
// imm_fmt: combinational immediate formatting for the IMM_SRC source word.
// MVT opcode moves the low half into the high half; anything else
// sign-extends the low IMM_W bits.
module imm_fmt
  import bus_mux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMM_W  = DEF_IMM_W
) (
  input  logic [DATA_W-1:0] src_i,
  output logic [DATA_W-1:0] res_o
);

  localparam int unsigned HALF_W = DATA_W / 2;
  localparam int unsigned EXT_W  = DATA_W - IMM_W;

  logic unused_src;
  assign unused_src = ^src_i;

  // Select between move-to-top and sign-extended immediate
  always_comb begin
    res_o = '0;
    if (src_i[DATA_W-1 -: OPC_W] == MVT) begin
      res_o = {src_i[HALF_W-1:0], HALF_W'(0)};
    end else begin
      res_o = {{EXT_W{src_i[IMM_W-1]}}, src_i[IMM_W-1:0]};
    end
  end

endmodule

// File: rtl/bus_mux_pipe.sv
// bus_mux_pipe: selects one of NUM_SRC packed sources, optionally formats the
// immediate source, and queues the result in a 2-entry skid FIFO.
// Optional feature macro: BUS_MUX_PIPE_IMM_EN enables immediate formatting
// of source IMM_SRC; without it that source passes through unchanged.
module bus_mux_pipe
  import bus_mux_pkg::*;
#(
  parameter  int unsigned DATA_W  = DEF_DATA_W,
  parameter  int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter  int unsigned IMM_SRC = DEF_IMM_SRC,
  parameter  int unsigned IMM_W   = DEF_IMM_W,
  localparam int unsigned SEL_W   = sel_width(NUM_SRC)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_SRC*DATA_W-1:0] src_bus,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_src,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err,
  input  logic                      err_clr
);

  localparam int unsigned CNT_W = 2;

  logic [DATA_W-1:0] fmt_src;
  logic [DATA_W-1:0] sel_data_c;
  logic              sel_oob_c;
  logic              push_c;
  logic              pop_c;

  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [SEL_W-1:0]  head_src_q,  head_src_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic [SEL_W-1:0]  tail_src_q,  tail_src_d;
  logic              err_q,       err_d;

`ifdef BUS_MUX_PIPE_IMM_EN
  imm_fmt #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_imm_fmt (
    .src_i (src_bus[IMM_SRC*DATA_W +: DATA_W]),
    .res_o (fmt_src)
  );
`else
  assign fmt_src = src_bus[IMM_SRC*DATA_W +: DATA_W];
`endif

  // Source mux; an out-of-range select matches nothing and yields zero
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_data_c = (i == IMM_SRC) ? fmt_src : src_bus[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_oob_c = ({1'b0, sel} >= (SEL_W+1)'(NUM_SRC));

  assign in_ready  = (cnt_q != CNT_W'(2));
  assign out_valid = (cnt_q != CNT_W'(0));
  assign out_data  = head_data_q;
  assign out_src   = head_src_q;
  assign sel_err   = err_q;

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  // FIFO and error-flag next state
  always_comb begin
    cnt_d       = cnt_q;
    head_data_d = head_data_q;
    head_src_d  = head_src_q;
    tail_data_d = tail_data_q;
    tail_src_d  = tail_src_q;
    err_d       = err_q;

    case ({push_c, pop_c})
      2'b10: begin
        if (cnt_q == CNT_W'(0)) begin
          head_data_d = sel_data_c;
          head_src_d  = sel;
        end else begin
          tail_data_d = sel_data_c;
          tail_src_d  = sel;
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
      2'b01: begin
        head_data_d = tail_data_q;
        head_src_d  = tail_src_q;
        cnt_d       = cnt_q - CNT_W'(1);
      end
      2'b11: begin
        // Occupancy unchanged; new entry goes behind whatever remains
        if (cnt_q == CNT_W'(1)) begin
          head_data_d = sel_data_c;
          head_src_d  = sel;
        end else begin
          head_data_d = tail_data_q;
          head_src_d  = tail_src_q;
          tail_data_d = sel_data_c;
          tail_src_d  = sel;
        end
      end
      default: ;
    endcase

    if (push_c && sel_oob_c) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      head_data_q <= '0;
      head_src_q  <= '0;
      tail_data_q <= '0;
      tail_src_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      head_data_q <= head_data_d;
      head_src_q  <= head_src_d;
      tail_data_q <= tail_data_d;
      tail_src_q  <= tail_src_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_mux_pipe.sv
// Testbench for bus_mux_pipe: queue-based scoreboard with a behavioural model.
module tb_bus_mux_pipe;

  localparam int DATA_W  = 16;
  localparam int NUM_SRC = 11;
  localparam int IMM_SRC = 8;
  localparam int SEL_W   = 4;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [SEL_W-1:0]  s;
  } exp_t;

  logic                      clock;
  logic                      resetn;
  logic [NUM_SRC*DATA_W-1:0] src_bus;
  logic [SEL_W-1:0]          sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         out_data;
  logic [SEL_W-1:0]          out_src;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sel_err;
  logic                      err_clr;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic err_m = 1'b0;

  bus_mux_pipe dut (
    .clock     (clock),
    .resetn    (resetn),
    .src_bus   (src_bus),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .err_clr   (err_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: out-of-range gives zero; the immediate source is formatted
  function automatic logic [DATA_W-1:0] model_word(input logic [NUM_SRC*DATA_W-1:0] bus, input int s);
    int w;
    int low;
    if (s >= NUM_SRC) return '0;
    w = int'(bus[s*DATA_W +: DATA_W]);
`ifdef BUS_MUX_PIPE_IMM_EN
    if (s == IMM_SRC) begin
      if ((w >> 13) == 1) return 16'((w % 256) * 256);
      low = w % 512;
      if (low >= 256) low = low - 512;
      return 16'(low);
    end
`else
    low = 0;
`endif
    return 16'(w);
  endfunction

  // Monitor: compare handshake flags, pop/compare head, then record accepts
  always @(negedge clock) begin
    if (!resetn) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      logic acc;
      exp_t e;
      check("in_ready", 32'(in_ready), 32'(q.size() != 2));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("sel_err", 32'(sel_err), 32'(err_m));
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) begin
        e = q.pop_front();
        check("out_data", 32'(out_data), 32'(e.d));
        check("out_src", 32'(out_src), 32'(e.s));
      end
      if (acc) begin
        e.d = model_word(src_bus, int'(sel));
        e.s = sel;
        q.push_back(e);
      end
      if (acc && int'(sel) >= NUM_SRC) err_m = 1'b1;
      else if (err_clr) err_m = 1'b0;
    end
  end

  task automatic set_src(input int idx, input logic [DATA_W-1:0] v);
    src_bus[idx*DATA_W +: DATA_W] = v;
  endtask

  // Apply inputs for the next edge, return 1 time unit after it
  task automatic cyc(input bit v, input int s, input bit ordy, input bit clr);
    in_valid  = v;
    sel       = 4'(s);
    out_ready = ordy;
    err_clr   = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0; src_bus = '0; sel = '0; in_valid = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 16'(32'h1000 + i * 32'h111));
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b1;

    // Basic select, one-cycle latency
    set_src(3, 16'hBEEF);
    cyc(1, 3, 1, 0);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_data", 32'(out_data), 32'hBEEF);
    check("basic_src", 32'(out_src), 32'd3);
    cyc(0, 0, 1, 0);

`ifdef BUS_MUX_PIPE_IMM_EN
    set_src(8, 16'h2155); cyc(1, 8, 1, 0);
    check("imm_mvt", 32'(out_data), 32'h5500);
    set_src(8, 16'h0180); cyc(1, 8, 1, 0);
    check("imm_neg", 32'(out_data), 32'hFF80);
    set_src(8, 16'h00FF); cyc(1, 8, 1, 0);
    check("imm_pos", 32'(out_data), 32'h00FF);
    cyc(0, 0, 1, 0);
`endif

    // Backpressure: fill, ignored third request, drain in order
    set_src(1, 16'hA001); set_src(2, 16'hA002); set_src(4, 16'hA004);
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    check("bp_full", 32'(in_ready), 32'd0);
    cyc(1, 4, 0, 0);
    check("bp_hold", 32'(out_data), 32'hA001);
    cyc(0, 0, 1, 0);
    check("bp_second", 32'(out_data), 32'hA002);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    // Simultaneous push and pop at occupancy 1
    set_src(5, 16'h5555); set_src(6, 16'h6666);
    cyc(1, 5, 0, 0);
    cyc(1, 6, 1, 0);
    check("pp_head", 32'(out_data), 32'h6666);
    check("pp_occ1", 32'({in_ready, out_valid}), 32'b11);
    cyc(0, 0, 1, 0);

    // Out-of-range select and set-beats-clear
    cyc(1, 12, 1, 0);
    check("oob_err", 32'(sel_err), 32'd1);
    check("oob_data", 32'(out_data), 32'd0);
    cyc(1, 13, 1, 1);
    check("oob_set_wins", 32'(sel_err), 32'd1);
    cyc(0, 0, 1, 1);
    check("oob_clr", 32'(sel_err), 32'd0);
    cyc(0, 0, 1, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_SRC; i++) set_src(i, 16'($urandom));
      if ($urandom % 4 == 0) set_src(IMM_SRC, {3'b001, 13'($urandom)});
      cyc(bit'($urandom % 2), int'($urandom_range(0, 15)),
          bit'($urandom % 4 != 0), bit'($urandom % 8 == 0));
    end

    // Reset mid-operation with two entries buffered
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    cyc(1, 12, 0, 0);
    cyc(1, 2, 0, 0);
    check("mid_full", 32'(in_ready), 32'd0);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_err", 32'(sel_err), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    set_src(7, 16'h7E57);
    cyc(1, 7, 1, 0);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data", 32'(out_data), 32'h7E57);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    check("drained", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
